// File: rtl/sae_search_engine.sv
// Block-matching search engine: buffers one reference block, scans (2R+1)^2
// candidate blocks in raster order and reports the minimum SAE with its vector.
module sae_search_engine #(
    parameter int WORD_SIZE    = 8,
    parameter int BLOCK_PIXELS = 4,
    parameter int ROWS         = 1,
    parameter int SEARCH_RANGE = 1,
    parameter int MV_W         = 3,
    localparam int SAE_W       = WORD_SIZE + $clog2(BLOCK_PIXELS * ROWS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              early_exit_en,
    input  logic                              ref_valid,
    input  logic [BLOCK_PIXELS*WORD_SIZE-1:0] ref_data,
    output logic                              ref_ready,
    input  logic                              cand_valid,
    input  logic [BLOCK_PIXELS*WORD_SIZE-1:0] cand_data,
    output logic                              cand_ready,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [MV_W-1:0]                   motion_vec_x,
    output logic [MV_W-1:0]                   motion_vec_y,
    output logic [SAE_W-1:0]                  min_sae,
    output logic                              early_exit
);

    localparam int DW = BLOCK_PIXELS * WORD_SIZE;
    localparam int N  = (2 * SEARCH_RANGE + 1) * (2 * SEARCH_RANGE + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [MV_W-1:0] LAST_X    = MV_W'(2 * SEARCH_RANGE);
    localparam logic [RW-1:0]   LAST_ROW  = RW'(ROWS - 1);
    localparam logic [CW-1:0]   LAST_CAND = CW'(N - 1);

    typedef enum logic [1:0] {LOAD_REF, ACC, DRAIN, RESULT} state_t;

    state_t            state;
    logic [RW-1:0]     row_cnt;
    logic [MV_W-1:0]   x_cnt;
    logic [MV_W-1:0]   y_cnt;
    logic [CW-1:0]     cand_cnt;
    logic [SAE_W-1:0]  acc;
    logic [SAE_W-1:0]  best;
    logic [MV_W-1:0]   best_x;
    logic [MV_W-1:0]   best_y;
    logic              ee_lat;
    logic              early_flag;
    logic [DW-1:0]     ref_buf [2**RW];
    logic [DW-1:0]     ref_row;
    logic [SAE_W-1:0]  row_sae;
    logic [SAE_W-1:0]  new_sae;
    logic              better;
    logic              last_row;
    logic              last_cand;
    logic              x_wrap;
    logic              ref_xfer;
    logic              cand_xfer;

    function automatic logic [SAE_W-1:0] abs_diff(input logic [WORD_SIZE-1:0] a,
                                                  input logic [WORD_SIZE-1:0] b);
        return (a > b) ? SAE_W'(a - b) : SAE_W'(b - a);
    endfunction

    assign ref_ready  = (state == LOAD_REF);
    assign cand_ready = (state == ACC) || (state == DRAIN);
    assign ref_xfer   = ref_valid && ref_ready;
    assign cand_xfer  = cand_valid && cand_ready;
    assign last_row   = (row_cnt == LAST_ROW);
    assign last_cand  = (cand_cnt == LAST_CAND);
    assign x_wrap     = (x_cnt == LAST_X);
    assign ref_row    = ref_buf[row_cnt];

    always_comb begin
        row_sae = '0;
        for (int unsigned p = 0; p < BLOCK_PIXELS; p++)
            row_sae = row_sae + abs_diff(ref_row[p*WORD_SIZE +: WORD_SIZE],
                                         cand_data[p*WORD_SIZE +: WORD_SIZE]);
    end

    assign new_sae = acc + row_sae;
    assign better  = (new_sae < best);

    // Reference rows are plain storage; validity is tracked by the FSM.
    always_ff @(posedge clk) begin
        if (ref_xfer)
            ref_buf[row_cnt] <= ref_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD_REF;
            row_cnt      <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            cand_cnt     <= '0;
            acc          <= '0;
            best         <= '1;
            best_x       <= '0;
            best_y       <= '0;
            ee_lat       <= 1'b0;
            early_flag   <= 1'b0;
            res_valid    <= 1'b0;
            motion_vec_x <= '0;
            motion_vec_y <= '0;
            min_sae      <= '0;
            early_exit   <= 1'b0;
        end else begin
            case (state)
                LOAD_REF: begin
                    if (ref_xfer) begin
                        if (row_cnt == '0)
                            ee_lat <= early_exit_en;
                        if (last_row) begin
                            state      <= ACC;
                            row_cnt    <= '0;
                            x_cnt      <= '0;
                            y_cnt      <= '0;
                            cand_cnt   <= '0;
                            acc        <= '0;
                            best       <= '1;
                            early_flag <= 1'b0;
                        end else begin
                            row_cnt <= row_cnt + RW'(1);
                        end
                    end
                end

                ACC, DRAIN: begin
                    if (cand_xfer) begin
                        if (!last_row) begin
                            row_cnt <= row_cnt + RW'(1);
                            if (state == ACC)
                                acc <= new_sae;
                        end else begin
                            row_cnt  <= '0;
                            acc      <= '0;
                            cand_cnt <= cand_cnt + CW'(1);
                            x_cnt    <= x_wrap ? '0 : x_cnt + MV_W'(1);
                            y_cnt    <= x_wrap ? y_cnt + MV_W'(1) : y_cnt;
                            if (state == ACC && better) begin
                                best   <= new_sae;
                                best_x <= x_cnt;
                                best_y <= y_cnt;
                            end
                            // The result registers take the winner including this
                            // candidate, so the update above is folded in here.
                            if (last_cand) begin
                                state      <= RESULT;
                                res_valid  <= 1'b1;
                                early_exit <= early_flag;
                                if (state == ACC && better) begin
                                    motion_vec_x <= x_cnt;
                                    motion_vec_y <= y_cnt;
                                    min_sae      <= new_sae;
                                end else begin
                                    motion_vec_x <= best_x;
                                    motion_vec_y <= best_y;
                                    min_sae      <= best;
                                end
                            end else if (state == ACC && ee_lat && new_sae == '0) begin
                                early_flag <= 1'b1;
                                state      <= DRAIN;
                            end
                        end
                    end
                end

                RESULT: begin
                    if (res_ready) begin
                        state     <= LOAD_REF;
                        res_valid <= 1'b0;
                        row_cnt   <= '0;
                    end
                end

                default: state <= LOAD_REF;
            endcase
        end
    end

endmodule

// File: doc/sae_search_engine.md
Name: sae_search_engine

Overview:
- Parametrised, handshake-driven successor to the fixed 9-candidate processor block in the motion compensation datapath.
- Buffers one reference block, then consumes (2R+1)^2 candidate blocks in raster order.
- Accumulates sum-of-absolute-errors (SAE) per candidate, row by row, and reports the minimum with its motion vector.
- Adds valid/ready flow control, multi-row blocks, a variable search range, and an optional zero-SAE early-exit mode.

Parameters:
- WORD_SIZE, 8: bits per pixel.
- BLOCK_PIXELS, 4: pixels per row word.
- ROWS, 1: row words per block.
- SEARCH_RANGE, 1: R; candidate count N=(2R+1)^2, raster order, x fastest.
- MV_W, 3: motion-vector component width; must be >= clog2(2R+1).
- Derived localparam SAE_W = WORD_SIZE+clog2(BLOCK_PIXELS*ROWS); 10 at defaults.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- early_exit_en  in  1  mode select; sampled when the first reference word is accepted.
- ref_valid  in  1  reference row word valid.
- ref_data  in  BLOCK_PIXELS*WORD_SIZE  reference row; pixel 0 in LSBs.
- ref_ready  out  1  engine accepts reference words.
- cand_valid  in  1  candidate row word valid.
- cand_data  in  BLOCK_PIXELS*WORD_SIZE  candidate row; same packing as ref_data.
- cand_ready  out  1  engine accepts candidate words.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- motion_vec_x  out  MV_W  column index 0..2R of the best candidate.
- motion_vec_y  out  MV_W  row index 0..2R of the best candidate.
- min_sae  out  SAE_W  best SAE.
- early_exit  out  1  result was produced by early exit.

Behaviour:
- Clock and reset: one clock is used (clk). rst_n is asynchronous and active-low.
- Reset values:
  - State LOAD_REF.
  - All counters 0; accumulator 0; best-SAE register all ones.
  - res_valid=0, motion_vec_x=0, motion_vec_y=0, min_sae=0, early_exit=0.
  - ref_ready=1, cand_ready=0.
- Ready signals: ref_ready=(state==LOAD_REF) and cand_ready=(state==ACC or DRAIN). Both are pure state decodes with no combinational path from the valids.
- Transfers: a transfer occurs only on a clock edge where valid&&ready.
- States:
  - LOAD_REF:
    - Each transfer stores ref_data in row buffer[row_cnt]; row_cnt++.
    - The first transfer also latches early_exit_en.
    - After ROWS transfers: go to ACC; clear row_cnt, cand x/y counters and accumulator; best-SAE = all ones.
  - ACC:
    - Each transfer computes row_sae = sum over pixels of |ref_buf[row_cnt][p] - cand[p]|, unsigned, no wrap, SAE_W wide.
    - new_sae = acc + row_sae.
    - Not last row: acc <= new_sae; row_cnt++.
    - Last row:
      - If new_sae < best (strict), best <= new_sae and best_x/y <= current x/y. Ties keep the earlier candidate.
      - acc <= 0.
      - Advance x; at 2R wrap x to 0 and y++.
    - Exit conditions:
      - Last row of candidate N-1: go to RESULT.
      - Else, if the latched early_exit_en=1 and new_sae==0: set the early flag and go to DRAIN.
  - DRAIN:
    - Accepts and discards candidate words until all N*ROWS words of this search are consumed, keeping the stream aligned.
    - Then goes to RESULT.
    - If the early-exit candidate was the last one, go straight to RESULT with no DRAIN cycles.
  - RESULT:
    - res_valid=1; outputs show best_x, best_y, best, and the early flag.
    - Outputs are registered and stable while res_valid && !res_ready.
    - On res_valid&&res_ready: go to LOAD_REF, res_valid <= 0. Data outputs hold their last values.
- Latency: res_valid rises on the clock edge after the final candidate word transfer (the last ACC word, or the last DRAIN word).
- Minimum cost per search: ROWS + N*ROWS + 1 cycles, with no gaps and res_ready held high.
- Bubbles: valid low simply stalls the engine; no timeout.
- Reset mid-search: aborts immediately to the reset state; partial data is discarded.
- Unused inputs: ref_valid in ACC/DRAIN/RESULT and cand_valid in LOAD_REF/RESULT are ignored.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with no clock edge -> immediately ref_ready=1, cand_ready=0, res_valid=0, min_sae=0, mv=(0,0), early_exit=0.
- Full search (defaults, early_exit_en=0):
  - ref=0x40302010; candidate 4 = 0x40302010; all other candidates = 0x41312111 (SAE 4).
  - -> all 9 words accepted; result mv=(1,1), min_sae=0, early_exit=0, res_valid one cycle after the 9th word.
- Early exit: same data with early_exit_en=1 -> ACC ends after word 5; 4 words drained; result mv=(1,1), min_sae=0, early_exit=1.
- Ties and maximum:
  - All 9 candidates SAE 8 -> mv=(0,0), min_sae=8.
  - ref=0xFFFFFFFF, all candidates 0x00000000 -> min_sae=1020, mv=(0,0).
- Multi-row (ROWS=4, SEARCH_RANGE=2, MV_W=3):
  - 25 candidates; candidate 17 has SAE 3 spread over rows 0 and 3; all others have SAE >= 5.
  - -> mv=(2,3), min_sae=3.
- Backpressure and reset:
  - Random cand_valid gaps -> identical result.
  - Hold res_ready=0 for 10 cycles -> res_valid and outputs stable, ref_ready=0.
  - Pulse rst_n low after 3 candidates -> LOAD_REF, res_valid=0; the next full search produces a correct result.
